// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and flag bit positions for the registered ALU.
package alu_seq_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

    // Bit positions inside the 4-bit flag word {carry, ovf, zero, err}.
    localparam int FLG_CARRY = 3;
    localparam int FLG_OVF   = 2;
    localparam int FLG_ZERO  = 1;
    localparam int FLG_ERR   = 0;

endpackage

// File: rtl/alu_seq_if.sv
// Board-side bundle: switch bus and buttons in, LED result and flags out.
interface alu_seq_if #(
    parameter int NB_DATA = 8,
    parameter int NB_SW   = 8
);
    // Buttons are raw asynchronous levels with no handshake; o_valid is a
    // one-cycle strobe marking the cycle in which o_leds/o_flags first show a new result.
    logic [NB_SW-1:0]   i_sw;
    logic               i_btn_a;
    logic               i_btn_b;
    logic               i_btn_op;
    logic [NB_DATA-1:0] o_leds;
    logic [3:0]         o_flags;
    logic               o_valid;

    modport master (
        output i_sw, i_btn_a, i_btn_b, i_btn_op,
        input  o_leds, o_flags, o_valid
    );

    modport slave (
        input  i_sw, i_btn_a, i_btn_b, i_btn_op,
        output o_leds, o_flags, o_valid
    );
endinterface

// File: rtl/alu_seq_core.sv
// Purely combinational ALU datapath: (a, b, op) -> result and status bits.
module alu_core
    import alu_seq_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic [NB_DATA-1:0] a,
    input  logic [NB_DATA-1:0] b,
    input  logic [NB_OP-1:0]   op,
    output logic [NB_DATA-1:0] result,
    output logic               carry,
    output logic               ovf,
    output logic               zero,
    output logic               err
);
    localparam logic [NB_DATA:0] SHIFT_LIM = (NB_DATA + 1)'(NB_DATA);

    logic [NB_DATA:0] wide;
    logic             big_shift;

    assign big_shift = {1'b0, b} >= SHIFT_LIM;

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        err    = 1'b0;
        wide   = '0;
        case (op)
            OP_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[NB_DATA-1:0];
                carry  = wide[NB_DATA];
                ovf    = (a[NB_DATA-1] == b[NB_DATA-1]) && (result[NB_DATA-1] != a[NB_DATA-1]);
            end
            OP_SUB: begin
                // The extra top bit of the widened difference is the borrow.
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[NB_DATA-1:0];
                carry  = wide[NB_DATA];
                ovf    = (a[NB_DATA-1] != b[NB_DATA-1]) && (result[NB_DATA-1] != a[NB_DATA-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOR: result = ~(a | b);
            OP_SRL: result = big_shift ? '0 : (a >> b);
            OP_SRA: result = big_shift ? {NB_DATA{a[NB_DATA-1]}}
                                       : NB_DATA'($signed(a) >>> b);
            default: err = 1'b1;
        endcase
    end

    assign zero = (result == '0) && !err;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU: three synchronised push-buttons load A, B and opcode from one
// switch bus; result and flags are registered and held until the next load.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6,
    parameter int NB_SW   = 8,
    parameter int N_SYNC  = 2
) (
    input  logic   clk,
    input  logic   i_rst_n,
    alu_seq_if.slave bus
);
    // Button index 0 = A, 1 = B, 2 = opcode.
    logic [2:0]        btn_raw;
    logic [N_SYNC-1:0] sync_q [3];
    logic [2:0]        hist_q;
    logic [2:0]        load;

    logic [NB_DATA-1:0] a_q, b_q;
    logic [NB_OP-1:0]   op_q;
    logic               load_pend_q;
    logic [NB_DATA-1:0] leds_q;
    logic [3:0]         flags_q;
    logic               valid_q;

    logic [NB_DATA-1:0] core_result;
    logic               core_carry, core_ovf, core_zero, core_err;

    assign btn_raw = {bus.i_btn_op, bus.i_btn_b, bus.i_btn_a};

    always_comb begin
        load = '0;
        for (int i = 0; i < 3; i++) begin
            load[i] = sync_q[i][N_SYNC-1] & ~hist_q[i];
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 3; i++) begin
                sync_q[i] <= '0;
            end
            hist_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                sync_q[i] <= {sync_q[i][N_SYNC-2:0], btn_raw[i]};
                hist_q[i] <= sync_q[i][N_SYNC-1];
            end
        end
    end

    // Simultaneous load pulses all capture the same switch value on one edge.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= NB_OP'(OP_ADD);
            load_pend_q <= 1'b0;
        end else begin
            if (load[0]) a_q  <= bus.i_sw[NB_DATA-1:0];
            if (load[1]) b_q  <= bus.i_sw[NB_DATA-1:0];
            if (load[2]) op_q <= bus.i_sw[NB_OP-1:0];
            load_pend_q <= |load;
        end
    end

    alu_core #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) u_core (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (core_result),
        .carry  (core_carry),
        .ovf    (core_ovf),
        .zero   (core_zero),
        .err    (core_err)
    );

    // An unknown opcode keeps the previous result and arithmetic flags, raising only err.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            leds_q  <= '0;
            flags_q <= 4'b0010;
            valid_q <= 1'b0;
        end else begin
            if (load_pend_q) begin
                if (core_err) begin
                    flags_q[FLG_ERR] <= 1'b1;
                end else begin
                    leds_q             <= core_result;
                    flags_q[FLG_CARRY] <= core_carry;
                    flags_q[FLG_OVF]   <= core_ovf;
                    flags_q[FLG_ZERO]  <= core_zero;
                    flags_q[FLG_ERR]   <= 1'b0;
                end
            end
            valid_q <= load_pend_q;
        end
    end

    assign bus.o_leds  = leds_q;
    assign bus.o_flags = flags_q;
    assign bus.o_valid = valid_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: loads operands/opcodes through the buttons and
// checks result, flags and o_valid timing against hand-computed values.
module tb_alu_seq;
    logic clk;
    logic i_rst_n;
    int   n_cmp;
    int   n_err;
    int   pulses;

    alu_seq_if #(.NB_DATA(8), .NB_SW(8)) bus ();

    alu_seq #(.NB_DATA(8), .NB_OP(6), .NB_SW(8), .N_SYNC(2)) dut (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mask bit0 = A, bit1 = B, bit2 = opcode.
    task automatic load(input logic [2:0] mask, input logic [7:0] val, input string tag);
        int lat;
        @(negedge clk);
        bus.i_sw     = val;
        bus.i_btn_a  = mask[0];
        bus.i_btn_b  = mask[1];
        bus.i_btn_op = mask[2];
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.o_valid) begin
                lat = i;
                break;
            end
        end
        // Button sampled at the first posedge; valid seen after the 4th posedge.
        check({tag, "_latency"}, 32'(lat), 32'd4);
        bus.i_btn_a  = 1'b0;
        bus.i_btn_b  = 1'b0;
        bus.i_btn_op = 1'b0;
        @(negedge clk);
        check({tag, "_valid_drop"}, 32'(bus.o_valid), 32'd0);
    endtask

    task automatic expect_out(input string tag, input logic [7:0] leds, input logic [3:0] flags);
        check({tag, "_leds"}, 32'(bus.o_leds), 32'(leds));
        check({tag, "_flags"}, 32'(bus.o_flags), 32'(flags));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus.i_sw     = '0;
        bus.i_btn_a  = 1'b0;
        bus.i_btn_b  = 1'b0;
        bus.i_btn_op = 1'b0;
        i_rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        expect_out("reset", 8'h00, 4'b0010);
        check("reset_valid", 32'(bus.o_valid), 32'd0);
        i_rst_n = 1'b1;
        @(negedge clk);

        // Signed overflow on ADD.
        load(3'b001, 8'h7F, "t2_a");  expect_out("t2_a", 8'h7F, 4'b0000);
        load(3'b010, 8'h01, "t2_b");  expect_out("t2_b", 8'h80, 4'b0100);
        load(3'b100, 8'h20, "t2_op"); expect_out("t2_op", 8'h80, 4'b0100);

        // SUB with borrow, then zero result.
        load(3'b001, 8'h05, "t3_a");  expect_out("t3_a", 8'h06, 4'b0000);
        load(3'b010, 8'h07, "t3_b");  expect_out("t3_b", 8'h0C, 4'b0000);
        load(3'b100, 8'h22, "t3_op"); expect_out("t3_sub", 8'hFE, 4'b1000);
        load(3'b001, 8'h07, "t3_a2"); expect_out("t3_zero", 8'h00, 4'b0010);

        // Shifts, including shift amounts beyond the width.
        load(3'b001, 8'h90, "t4_a");   expect_out("t4_sub", 8'h89, 4'b0000);
        load(3'b010, 8'h02, "t4_b");   expect_out("t4_sub2", 8'h8E, 4'b0000);
        load(3'b100, 8'h03, "t4_sra"); expect_out("t4_sra2", 8'hE4, 4'b0000);
        load(3'b100, 8'h02, "t4_srl"); expect_out("t4_srl2", 8'h24, 4'b0000);
        load(3'b010, 8'h09, "t4_b9");  expect_out("t4_srl9", 8'h00, 4'b0010);
        load(3'b100, 8'h03, "t4_sra9"); expect_out("t4_sra9", 8'hFF, 4'b0000);

        // Held button: exactly one load and one valid pulse.
        @(negedge clk);
        bus.i_sw    = 8'h33;
        bus.i_btn_a = 1'b1;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.o_valid) pulses++;
        end
        bus.i_btn_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.o_valid) pulses++;
        end
        check("t5_held_pulses", 32'(pulses), 32'd1);
        expect_out("t5_held_sra", 8'h00, 4'b0010);
        load(3'b100, 8'h26, "t5_xor");  expect_out("t5_xor", 8'h3A, 4'b0000);
        load(3'b011, 8'h33, "t5_both"); expect_out("t5_both", 8'h00, 4'b0010);

        // Unknown opcode holds result and arithmetic flags.
        load(3'b100, 8'h20, "t6_add");  expect_out("t6_add", 8'h66, 4'b0000);
        load(3'b001, 8'h7F, "t6_a");    expect_out("t6_a", 8'hB2, 4'b0100);
        load(3'b010, 8'h01, "t6_b");    expect_out("t6_b", 8'h80, 4'b0100);
        load(3'b100, 8'h3F, "t6_bad");  expect_out("t6_bad", 8'h80, 4'b0101);
        load(3'b100, 8'h24, "t6_and");  expect_out("t6_and", 8'h01, 4'b0000);

        // Asynchronous reset between edges takes effect before the next edge.
        @(posedge clk);
        #2 i_rst_n = 1'b0;
        #1;
        expect_out("t1_async", 8'h00, 4'b0010);
        check("t1_async_valid", 32'(bus.o_valid), 32'd0);
        @(negedge clk);
        i_rst_n = 1'b1;

        // Reset during a load drops that load.
        @(negedge clk);
        bus.i_sw    = 8'h55;
        bus.i_btn_a = 1'b1;
        @(negedge clk);
        i_rst_n = 1'b0;
        @(negedge clk);
        bus.i_btn_a = 1'b0;
        i_rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.o_valid) pulses++;
        end
        check("t1_drop_pulses", 32'(pulses), 32'd0);
        load(3'b010, 8'h05, "t1_b");    expect_out("t1_after", 8'h05, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
